// File: rtl/dm_resp.sv
// Data-memory bus responder: one outstanding load/store on a valid/ready pair,
// serviced from a byte-lane RAM after LATENCY cycles, answered on a valid/ready response.
module dm_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dm_resp: LATENCY must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        err_reg, err_next;
  logic        load_reg, load_next;

  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;

  logic        accept;
  logic        commit;
  logic        c_we;
  logic        c_err;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_be;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [31:0] rd_word;

  assign accept = (state_reg == IDLE) && req_valid;

  // With a single-cycle latency the acceptance edge is also the commit edge,
  // so the RAM is addressed straight from the bus instead of the request register.
  assign commit = ((state_reg == WAIT) && (cnt_reg == 4'd1)) ||
                  (accept && (LATENCY == 1));

  assign c_we    = (state_reg == IDLE) ? req_we    : we_reg;
  assign c_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign c_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign c_be    = (state_reg == IDLE) ? req_be    : be_reg;
  assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:DEPTH_LOG2+2] != '0);
  assign c_idx   = c_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      err_reg   <= 1'b0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      load_reg  <= load_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    load_next  = load_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          cnt_next   = 4'(LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
          err_next   = 1'b0;
          load_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (commit) begin
      state_next = RESP;
      cnt_next   = 4'd0;
      err_next   = c_err;
      load_next  = !c_we && !c_err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      be_reg    <= req_be;
    end
  end

  // One RAM per byte lane; the read port only updates on commit so the
  // response data stays put for as long as the requester stalls.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (commit && c_we && !c_err && c_be[gi])
          mem[c_idx] <= c_wdata[8*gi +: 8];
        if (commit)
          rd_q <= mem[c_idx];
      end
      assign rd_word[8*gi +: 8] = rd_q;
    end
  endgenerate

  assign rsp_rdata = load_reg ? rd_word : 32'd0;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: three builds (LATENCY 2, 1, 4) driven by directed and random
// transactions, checked every cycle against a transaction-level memory model.
`timescale 1ns/1ps
module tb_dm_resp;

  localparam int N = 3;
  localparam int LATS [N] = '{2, 1, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [N];
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_we    [N];
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic [3:0]  req_be    [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  // Transaction-level model: one pending request, a word memory, and the
  // edge number at which the response must appear.
  logic        m_busy   [N] = '{default: 1'b0};
  logic        m_resp   [N] = '{default: 1'b0};
  logic        m_err    [N] = '{default: 1'b0};
  logic [31:0] m_rd     [N] = '{default: 32'd0};
  int          m_ecnt   [N] = '{default: 0};
  int          m_commit [N] = '{default: 0};
  logic        p_we     [N];
  logic [31:0] p_addr   [N];
  logic [31:0] p_wdata  [N];
  logic [3:0]  p_be     [N];
  logic [31:0] mmem     [N][1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void commit_model(input int i);
    logic        e;
    logic [31:0] w;
    int          idx;
    e = (p_addr[i] % 4 != 0) || (p_addr[i] >= 32'h1000);
    m_resp[i] = 1'b1;
    m_err[i]  = e;
    m_rd[i]   = 32'd0;
    if (!e) begin
      idx = int'(p_addr[i] / 4);
      w = mmem[i][idx];
      if (!p_we[i]) m_rd[i] = w;
      else begin
        for (int b = 0; b < 4; b++)
          if (p_be[i][b]) w[8*b +: 8] = p_wdata[i][8*b +: 8];
        mmem[i][idx] = w;
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_inst
      dm_resp #(.DEPTH_LOG2(10), .LATENCY(LATS[gi])) dut (
        .clk       (clk),
        .rst       (rst[gi]),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .req_be    (req_be[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi])
      );

      always @(posedge clk or negedge rst[gi]) begin
        if (!rst[gi]) begin
          m_busy[gi] = 1'b0;
          m_resp[gi] = 1'b0;
          m_err[gi]  = 1'b0;
          m_rd[gi]   = 32'd0;
        end else begin
          m_ecnt[gi] = m_ecnt[gi] + 1;
          if (m_resp[gi]) begin
            if (rsp_ready[gi]) begin
              m_resp[gi] = 1'b0;
              m_busy[gi] = 1'b0;
              m_err[gi]  = 1'b0;
              m_rd[gi]   = 32'd0;
            end
          end else if (m_busy[gi]) begin
            if (m_ecnt[gi] == m_commit[gi]) commit_model(gi);
          end else if (req_valid[gi]) begin
            p_we[gi]     = req_we[gi];
            p_addr[gi]   = req_addr[gi];
            p_wdata[gi]  = req_wdata[gi];
            p_be[gi]     = req_be[gi];
            m_busy[gi]   = 1'b1;
            m_commit[gi] = m_ecnt[gi] + LATS[gi] - 1;
            if (LATS[gi] == 1) commit_model(gi);
          end
        end
      end
    end
  endgenerate

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("req_ready[%0d]", i), 32'(req_ready[i]), 32'(!m_busy[i]));
        chk($sformatf("rsp_valid[%0d]", i), 32'(rsp_valid[i]), 32'(m_resp[i]));
        chk($sformatf("rsp_err[%0d]", i),   32'(rsp_err[i]),   32'(m_err[i]));
        chk($sformatf("rsp_rdata[%0d]", i), rsp_rdata[i],      m_rd[i]);
      end
    end
  end

  task automatic reset_pulse(input int i);
    #2 rst[i] = 1'b0;
    #1;
    chk("async_req_ready", 32'(req_ready[i]), 32'd1);
    chk("async_rsp_valid", 32'(rsp_valid[i]), 32'd0);
    chk("async_rsp_err",   32'(rsp_err[i]),   32'd0);
    chk("async_rsp_rdata", rsp_rdata[i],      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst[i] = 1'b1;
  endtask

  // Called at a negedge; returns at a negedge. abort: 1 = reset in WAIT, 2 = reset in RESP.
  task automatic txn(input int i, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int hold,
                     input int abort, output logic [31:0] rd, output logic er,
                     output int lat, output longint acc_t);
    int k;
    rd = 32'd0; er = 1'b0; lat = 0; acc_t = 0;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr;
    req_wdata[i] = wd;   req_be[i] = be;
    k = 0;
    while (!req_ready[i] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready[i]) begin
      total++; bad++;
      $display("FAIL accept_timeout inst %0d: req_ready=%0d want 1", i, req_ready[i]);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    acc_t = longint'($time);
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid[i] = 1'b0;
        req_we[i] = 1'($urandom); req_addr[i] = $urandom;
        req_wdata[i] = $urandom;  req_be[i] = 4'($urandom);
        if (abort == 1) begin
          reset_pulse(i);
          return;
        end
      end
    end while (!rsp_valid[i] && lat < 50);
    if (!rsp_valid[i]) begin
      total++; bad++;
      $display("FAIL rsp_timeout inst %0d: rsp_valid=%0d want 1", i, rsp_valid[i]);
      return;
    end
    if (abort == 2) begin
      reset_pulse(i);
      return;
    end
    rd = rsp_rdata[i];
    er = rsp_err[i];
    for (int h = 0; h < hold; h++) begin
      req_valid[i] = 1'b1;
      @(negedge clk);
    end
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    req_valid[i] = 1'b0;
    rsp_ready[i] = (i == 1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  longint      t0, t1;

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0; req_be[i] = 4'd0;
      rsp_ready[i] = (i == 1);
    end
    #1;
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("reset_req_ready", 32'(req_ready[i]), 32'd1);
      chk("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[i], 32'd0);
      chk("reset_rsp_err",   32'(rsp_err[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b1;
    chk_on = 1'b1;

    // Known contents in the low 32 words of every build.
    for (int i = 0; i < N; i++)
      for (int w = 0; w < 32; w++)
        txn(i, 1'b1, 32'(w * 4), 32'hA500_0000 | 32'(w), 4'hF, 0, 0, rd, er, lat, t0);

    // LATENCY=2 build: directed cases.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat, t0);
    chk("store_lat", 32'(lat), 32'd2);
    chk("store_rdata", rd, 32'd0);
    chk("store_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("load_lat", 32'(lat), 32'd2);
    chk("load_rdata", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 0, rd, er, lat, t0);
    txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, rd, er, lat, t0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("be_merge", rd, 32'h11BB33DD);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("misalign_err", 32'(er), 32'd1);
    chk("misalign_rdata", rd, 32'd0);
    txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lat, t0);
    chk("oob_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("after_err_rdata", rd, 32'hA500_0000);
    chk("after_err_err", 32'(er), 32'd0);
    txn(0, 1'b1, 32'h24, 32'h12345678, 4'h0, 0, 0, rd, er, lat, t0);
    chk("be0_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h24, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("be0_unchanged", rd, 32'hA500_0009);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 0, rd, er, lat, t0);
    chk("backpressure_rdata", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h44, 32'h12345678, 4'hF, 0, 2, rd, er, lat, t0);
    txn(0, 1'b0, 32'h44, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("reset_in_resp_kept", rd, 32'h12345678);

    // LATENCY=1 build: back-to-back loads.
    txn(1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("l1_lat", 32'(lat), 32'd1);
    chk("l1_rdata0", rd, 32'hA500_0000);
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 0, rd, er, lat, t1);
    chk("l1_rdata1", rd, 32'hA500_0001);
    chk("l1_interval", 32'((t1 - t0) / 10), 32'd2);

    // LATENCY=4 build: reset during the wait aborts the store.
    txn(2, 1'b1, 32'h40, 32'h55, 4'hF, 0, 1, rd, er, lat, t0);
    txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 0, 0, rd, er, lat, t0);
    chk("l4_lat", 32'(lat), 32'd4);
    chk("abort_old_value", rd, 32'hA500_0010);

    // Random traffic on every build; the per-cycle compare does the checking.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        if (r < 8)       a = 32'($urandom_range(0, 31)) << 2;
        else if (r == 8) a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
        else             a = $urandom | 32'h1000;
        txn(i, 1'($urandom), a, $urandom, 4'($urandom),
            (i == 1) ? 0 : int'($urandom_range(0, 3)), 0, rd, er, lat, t0);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
